ddr_traffic_gen: RTL and testbench

- Synthesizable initiator for the memory-controller access-command interface (command/valid/write_data in, read_data/read_data_valid/ba_cmd_pm back).
- Issues a write sweep over NUM_TXN addresses, then a read sweep over the same addresses, and checks every returned burst against a regenerated expected pattern.
- Sits in place of the simulation stimulus block, so the controller can be exercised on silicon/FPGA with pass/fail and error capture.

---
 rtl/ddr_traffic_gen.sv | 184 ++++++++++++++++++
 tb/tb_ddr_traffic_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_traffic_gen.sv
// Write-then-read sweep generator and checker for the DDR access-command port.
// Optional watchdog and timeout port: define TGEN_TIMEOUT_EN.
module ddr_traffic_gen #(
    parameter int          NUM_TXN         = 256,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] SEED            = 32'hA5A5_0000,
    parameter int          DATA_W          = 128,
    parameter int          CMD_W           = 32
) (
    input  logic              clk,
    input  logic              power_on_rst,
    input  logic              start,
    output logic [CMD_W-1:0]  command,
    output logic              valid,
    output logic [DATA_W-1:0] write_data,
    input  logic              ba_cmd_pm,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_idx
`ifdef TGEN_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int          LANES   = DATA_W / 32;
    localparam logic [15:0] LAST    = 16'(NUM_TXN - 1);
    localparam logic [4:0]  MAX_OUT = 5'(MAX_OUTSTANDING);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic [15:0] wr_idx;
    logic [15:0] rd_idx;
    logic [15:0] chk_idx;
    logic [4:0]  outstanding;

    logic [15:0] cur_idx;
    logic [31:0] cmd32;
    logic        rw;
    logic        issuing;
    logic        hs;
    logic        rd_ok;
    logic        rd_bad;
    logic        mismatch;
    logic        err_hit;
    logic        start_run;

    function automatic logic [DATA_W-1:0] pattern(input logic [15:0] i);
        logic [31:0]       w;
        logic [DATA_W-1:0] p;
        w = SEED ^ {16'h0, i};
        p = '0;
        for (int k = 0; k < LANES; k++) begin
            p[k*32 +: 32] = w + 32'(k);
        end
        return p;
    endfunction

    assign rw      = (state == S_READ);
    assign issuing = (state == S_WRITE) || (state == S_READ);
    assign cur_idx = rw ? rd_idx : wr_idx;
    assign cmd32   = {rw, 8'h00, cur_idx[15:10], cur_idx[9:7],
                      cur_idx[6:0], 3'b000, 4'b0000};

    assign valid = (state == S_WRITE) ||
                   (state == S_READ && outstanding < MAX_OUT);
    assign hs    = valid && ba_cmd_pm;

    always_comb begin
        command = '0;
        if (issuing) begin
            command[31:0] = cmd32;
        end
    end

    assign write_data = (state == S_WRITE) ? pattern(wr_idx) : '0;

    // A return is only legitimate while reads can be in flight.
    assign rd_ok    = read_data_valid && outstanding != 5'd0 &&
                      (state == S_READ || state == S_DRAIN);
    assign rd_bad   = read_data_valid && !rd_ok;
    assign mismatch = rd_ok && (read_data != pattern(chk_idx));
    assign err_hit  = rd_bad || mismatch;

    assign start_run = start && (state == S_IDLE || state == S_DONE);

    assign busy = (state == S_WRITE) || (state == S_GAP) ||
                  (state == S_READ) || (state == S_DRAIN);
    assign done = (state == S_DONE);

`ifdef TGEN_TIMEOUT_EN
    logic [19:0] wdog;
    assign pass = done && err_count == 16'h0 && !timeout;
`else
    assign pass = done && err_count == 16'h0;
`endif

    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            state         <= S_IDLE;
            wr_idx        <= '0;
            rd_idx        <= '0;
            chk_idx       <= '0;
            outstanding   <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else if (start_run) begin
            state         <= S_WRITE;
            wr_idx        <= '0;
            rd_idx        <= '0;
            chk_idx       <= '0;
            outstanding   <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_WRITE: begin
                    if (hs) begin
                        wr_idx <= wr_idx + 16'd1;
                        if (wr_idx == LAST) state <= S_GAP;
                    end
                end
                S_GAP:   state <= S_READ;
                S_READ: begin
                    if (hs) begin
                        rd_idx <= rd_idx + 16'd1;
                        if (rd_idx == LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == 5'd0) state <= S_DONE;
                end
                default: ;
            endcase

            outstanding <= outstanding + {4'b0, hs && rw} - {4'b0, rd_ok};

            if (rd_ok) chk_idx <= chk_idx + 16'd1;

            if (err_hit) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'h0) begin
                    first_err_idx <= rd_bad ? 16'hFFFF : chk_idx;
                end
            end

`ifdef TGEN_TIMEOUT_EN
            if (busy && !hs && !read_data_valid && wdog == 20'hFFFFF) begin
                state <= S_DONE;
            end
`endif
        end
    end

`ifdef TGEN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (start_run) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (!busy || hs || read_data_valid) begin
            wdog <= '0;
        end else if (wdog == 20'hFFFFF) begin
            wdog    <= '0;
            timeout <= 1'b1;
        end else begin
            wdog <= wdog + 20'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Scoreboard bench for ddr_traffic_gen: memory model, stall, hold,
// corruption, spurious-return and mid-run reset cases.
module tb_ddr_traffic_gen;

    localparam int N    = 12;
    localparam int MAXO = 8;
    localparam int DW   = 128;

    logic          clk = 1'b0;
    logic          power_on_rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   command;
    logic          valid;
    logic [DW-1:0] write_data;
    logic          ba_cmd_pm = 1'b1;
    logic [DW-1:0] read_data = '0;
    logic          read_data_valid = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [15:0]   first_err_idx;
`ifdef TGEN_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    ddr_traffic_gen #(
        .NUM_TXN(N),
        .MAX_OUTSTANDING(MAXO),
        .SEED(32'hA5A5_0000),
        .DATA_W(DW),
        .CMD_W(32)
    ) dut (
        .clk(clk),
        .power_on_rst(power_on_rst),
        .start(start),
        .command(command),
        .valid(valid),
        .write_data(write_data),
        .ba_cmd_pm(ba_cmd_pm),
        .read_data(read_data),
        .read_data_valid(read_data_valid),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_idx(first_err_idx)
`ifdef TGEN_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    logic [31:0]   exp_cmd_q[$];
    logic [DW-1:0] exp_wd_q[$];
    int            ret_idx_q[$];
    int            ret_due_q[$];
    logic [DW-1:0] mem [0:127];

    int cyc = 0;
    int n_wr_hs = 0;
    int n_rd_hs = 0;
    int n_ret = 0;
    bit toggle_mode = 0;
    bit hold_mode = 0;
    bit corrupt_mode = 0;
    bit inject = 0;

    // SEED has zero low half, so SEED ^ i is SEED | i; col sits at bit 7 for i < 128.
    function automatic logic [31:0] e_cmd(int i, bit rd);
        return {rd, 31'(i << 7)};
    endfunction

    function automatic logic [DW-1:0] e_wd(int i);
        logic [DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = (32'hA5A5_0000 | 32'(i)) + 32'(k);
        return r;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Controller/memory model: drives ready and in-order read returns.
    always @(posedge clk) begin
        #1;
        ba_cmd_pm = toggle_mode ? ~ba_cmd_pm : 1'b1;
        read_data_valid = 1'b0;
        read_data = '0;
        if (inject) begin
            inject = 0;
            read_data_valid = 1'b1;
        end else if (ret_idx_q.size() > 0 && !hold_mode && ret_due_q[0] <= cyc) begin
            int i;
            i = ret_idx_q.pop_front();
            void'(ret_due_q.pop_front());
            read_data = mem[i];
            if (corrupt_mode && (i == 2 || i == 3)) read_data[0] = ~read_data[0];
            read_data_valid = 1'b1;
            n_ret++;
        end
    end

    bit            stall_prev = 0;
    logic [31:0]   prev_cmd;
    logic [DW-1:0] prev_wd;
    int            gap_chk = 0;

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (power_on_rst) begin
            stall_prev = 0;
            gap_chk = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {127'b0, valid}, 1);
                check("stall_cmd", {96'b0, command}, {96'b0, prev_cmd});
                check("stall_wdata", write_data, prev_wd);
            end
            if (gap_chk == 2) begin
                check("gap_valid_low", {127'b0, valid}, 0);
                gap_chk = 1;
            end else if (gap_chk == 1 && valid) begin
                check("read_after_gap", {127'b0, command[31]}, 1);
                gap_chk = 0;
            end
            if (valid && ba_cmd_pm) begin
                int idx;
                idx = int'(command[13:7]);
                compared++;
                if (exp_cmd_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_hs: got cmd %0h expected none", command);
                end else begin
                    logic [31:0]   ec;
                    logic [DW-1:0] ed;
                    ec = exp_cmd_q.pop_front();
                    ed = exp_wd_q.pop_front();
                    if (command !== ec || write_data !== ed) begin
                        mismatched++;
                        $display("FAIL hs_cmd: got %0h/%0h expected %0h/%0h",
                                 command, write_data, ec, ed);
                    end
                end
                if (command[31]) begin
                    n_rd_hs++;
                    ret_idx_q.push_back(idx);
                    ret_due_q.push_back(cyc + 10);
                end else begin
                    n_wr_hs++;
                    mem[idx] = write_data;
                    if (idx == N - 1) gap_chk = 2;
                end
            end
            stall_prev = valid && !ba_cmd_pm;
            prev_cmd = command;
            prev_wd = write_data;
        end
    end

    task automatic start_run();
        for (int i = 0; i < N; i++) begin
            exp_cmd_q.push_back(e_cmd(i, 0));
            exp_wd_q.push_back(e_wd(i));
        end
        for (int i = 0; i < N; i++) begin
            exp_cmd_q.push_back(e_cmd(i, 1));
            exp_wd_q.push_back('0);
        end
        n_wr_hs = 0;
        n_rd_hs = 0;
        n_ret = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic finish_run(string tag, int exp_err, logic [15:0] exp_first);
        int t;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL %s_done_wait: got done=0 expected done=1", tag);
        end
        @(negedge clk);
        check({tag, "_done"}, {127'b0, done}, 1);
        check({tag, "_busy"}, {127'b0, busy}, 0);
        check({tag, "_pass"}, {127'b0, pass}, {127'b0, exp_err == 0});
        check({tag, "_err"}, {112'b0, err_count}, 128'(exp_err));
        check({tag, "_first"}, {112'b0, first_err_idx}, {112'b0, exp_first});
        check({tag, "_wr_hs"}, 128'(n_wr_hs), 128'(N));
        check({tag, "_rd_hs"}, 128'(n_rd_hs), 128'(N));
        check({tag, "_sb_empty"}, 128'(exp_cmd_q.size()), 0);
    endtask

    task automatic wait_reads(int n);
        int t;
        t = 0;
        while (n_rd_hs < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (n_rd_hs < n) begin
            compared++;
            mismatched++;
            $display("FAIL read_wait: got %0d reads expected %0d", n_rd_hs, n);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 power_on_rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {127'b0, valid}, 0);
        check("rst_busy", {127'b0, busy}, 0);
        check("rst_done", {127'b0, done}, 0);
        check("rst_pass", {127'b0, pass}, 0);
        check("rst_err", {112'b0, err_count}, 0);
        check("rst_first", {112'b0, first_err_idx}, 0);
        check("rst_cmd", {96'b0, command}, 0);
        check("rst_wdata", write_data, 0);

        start_run();
        finish_run("basic", 0, 16'h0);

        // Stray return while in DONE.
        @(posedge clk); #2 inject = 1;
        repeat (3) @(negedge clk);
        check("spur_err", {112'b0, err_count}, 1);
        check("spur_first", {112'b0, first_err_idx}, 128'h0FFFF);
        check("spur_pass", {127'b0, pass}, 0);

        toggle_mode = 1;
        start_run();
        finish_run("toggle", 0, 16'h0);
        toggle_mode = 0;

        hold_mode = 1;
        start_run();
        wait_reads(MAXO);
        repeat (3) begin
            @(negedge clk);
            check("hold_valid_low", {127'b0, valid}, 0);
        end
        hold_mode = 0;
        begin
            int t;
            t = 0;
            while (n_ret < 1 && t < 100) begin
                @(posedge clk); #2;
                t++;
            end
        end
        @(negedge clk);
        check("hold_first_ret_cycle", {127'b0, valid}, 0);
        @(negedge clk);
        check("hold_resume", {127'b0, valid}, 1);
        finish_run("hold", 0, 16'h0);

        corrupt_mode = 1;
        start_run();
        finish_run("corrupt", 2, 16'd2);
        corrupt_mode = 0;

        start_run();
        wait_reads(3);
        @(posedge clk); #2 power_on_rst = 1'b1;
        exp_cmd_q.delete();
        exp_wd_q.delete();
        ret_idx_q.delete();
        ret_due_q.delete();
        @(posedge clk); #2;
        check("mid_rst_valid", {127'b0, valid}, 0);
        check("mid_rst_busy", {127'b0, busy}, 0);
        check("mid_rst_err", {112'b0, err_count}, 0);
        power_on_rst = 1'b0;
        repeat (15) @(posedge clk);
        start_run();
        finish_run("after_rst", 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
